// File: rtl/rpc_dram_responder_if.sv
// rtl/rpc_dram_responder_if.sv - RPC DRAM pin bundle between controller PHY and device responder
interface rpc_dram_responder_if;
  logic        rpc_cs_ni;
  logic        rpc_stb_i;
  logic [15:0] db_i;
  logic        dqs_i;
  logic [15:0] db_o;
  logic        db_oe_o;
  logic        dqs_o;
  logic        dqs_n_o;
  logic        dqs_oe_o;

  modport master (
    output rpc_cs_ni, rpc_stb_i, db_i, dqs_i,
    input  db_o, db_oe_o, dqs_o, dqs_n_o, dqs_oe_o
  );

  modport slave (
    input  rpc_cs_ni, rpc_stb_i, db_i, dqs_i,
    output db_o, db_oe_o, dqs_o, dqs_n_o, dqs_oe_o
  );
endinterface

// File: rtl/rpc_dram_responder.sv
// rtl/rpc_dram_responder.sv - RPC DRAM device endpoint: command decode, write absorb, latency-timed read return
module rpc_dram_responder #(
  parameter int MemDepth  = 1024,
  parameter int RdLatency = 4,
  parameter int WrLatency = 2,
  parameter int AddrWidth = 20,
  parameter int LenWidth  = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  rpc_dram_responder_if.slave  rpc,
  output logic [7:0]           err_cnt_o,
  output logic                 busy_o
);

  localparam int IdxW = $clog2(MemDepth);
  localparam logic [3:0] OpWrite = 4'h1;
  localparam logic [3:0] OpRead  = 4'h2;

  typedef enum logic [2:0] {
    IDLE, CMD1, WR_WAIT, WR_DATA, RD_WAIT, RD_PRE, RD_DATA, RD_POST
  } state_t;

  state_t                state;
  logic [3:0]            op;
  logic [11:0]           addr_lo;
  logic [IdxW-1:0]       ptr;
  logic [LenWidth-1:0]   len;
  logic [LenWidth-1:0]   beats_left;
  logic [3:0]            lat_cnt;
  logic [15:0]           db_q;
  logic                  db_oe_q;
  logic                  dqs_q;
  logic                  dqs_oe_q;
  logic [7:0]            err_cnt;
  logic                  err_evt;
  logic                  wr_en;
  logic                  abort;
  logic [AddrWidth-1:0]  addr_full;
  logic                  unused_bits;

  logic [15:0] mem [MemDepth];

  assign addr_full   = {rpc.db_i[15:8], addr_lo};
  assign unused_bits = ^{addr_full, rpc.db_i[1:0]};
  assign abort       = (state != IDLE) && rpc.rpc_cs_ni;

  // All error sources collapse into one event so simultaneous faults bump the count once.
  always_comb begin
    err_evt = 1'b0;
    wr_en   = 1'b0;
    if (abort) begin
      err_evt = (state == WR_DATA);
    end else begin
      case (state)
        CMD1:    err_evt = !rpc.rpc_stb_i || (op != OpWrite && op != OpRead);
        WR_WAIT: begin
          wr_en   = rpc.dqs_i;
          err_evt = rpc.rpc_stb_i || (!rpc.dqs_i && lat_cnt == 4'(WrLatency - 1));
        end
        WR_DATA: begin
          wr_en   = rpc.dqs_i;
          err_evt = rpc.rpc_stb_i;
        end
        RD_WAIT, RD_PRE, RD_DATA, RD_POST: err_evt = rpc.rpc_stb_i;
        default: err_evt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en && !rst_i) mem[ptr] <= rpc.db_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      op         <= '0;
      addr_lo    <= '0;
      ptr        <= '0;
      len        <= '0;
      beats_left <= '0;
      lat_cnt    <= '0;
      db_q       <= '0;
      db_oe_q    <= 1'b0;
      dqs_q      <= 1'b0;
      dqs_oe_q   <= 1'b0;
      err_cnt    <= '0;
    end else begin
      if (err_evt && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      if (abort) begin
        state    <= IDLE;
        db_q     <= '0;
        db_oe_q  <= 1'b0;
        dqs_q    <= 1'b0;
        dqs_oe_q <= 1'b0;
      end else begin
        case (state)
          IDLE: if (!rpc.rpc_cs_ni && rpc.rpc_stb_i) begin
            op      <= rpc.db_i[15:12];
            addr_lo <= rpc.db_i[11:0];
            state   <= CMD1;
          end
          CMD1: begin
            if (!rpc.rpc_stb_i) begin
              state <= IDLE;
            end else begin
              ptr     <= addr_full[IdxW-1:0];
              len     <= rpc.db_i[2 +: LenWidth];
              lat_cnt <= '0;
              if (op == OpWrite) begin
                state <= WR_WAIT;
              end else if (op == OpRead) begin
                if (RdLatency == 1) begin
                  state    <= RD_PRE;
                  dqs_oe_q <= 1'b1;
                end else begin
                  state <= RD_WAIT;
                end
              end else begin
                state <= IDLE;
              end
            end
          end
          WR_WAIT: begin
            if (rpc.dqs_i) begin
              ptr        <= ptr + IdxW'(1);
              beats_left <= len;
              state      <= (len == '0) ? IDLE : WR_DATA;
            end else if (lat_cnt == 4'(WrLatency - 1)) begin
              state <= IDLE;
            end else begin
              lat_cnt <= lat_cnt + 4'd1;
            end
          end
          WR_DATA: if (rpc.dqs_i) begin
            ptr        <= ptr + IdxW'(1);
            beats_left <= beats_left - LenWidth'(1);
            if (beats_left == LenWidth'(1)) state <= IDLE;
          end
          RD_WAIT: begin
            if (lat_cnt == 4'(RdLatency - 2)) begin
              state    <= RD_PRE;
              dqs_oe_q <= 1'b1;
              dqs_q    <= 1'b0;
            end else begin
              lat_cnt <= lat_cnt + 4'd1;
            end
          end
          // Registered memory read: the first word is fetched during the preamble.
          RD_PRE: begin
            db_q       <= mem[ptr];
            ptr        <= ptr + IdxW'(1);
            db_oe_q    <= 1'b1;
            dqs_q      <= 1'b1;
            beats_left <= len;
            state      <= RD_DATA;
          end
          RD_DATA: begin
            if (beats_left == '0) begin
              db_q    <= '0;
              db_oe_q <= 1'b0;
              dqs_q   <= 1'b0;
              state   <= RD_POST;
            end else begin
              db_q       <= mem[ptr];
              ptr        <= ptr + IdxW'(1);
              beats_left <= beats_left - LenWidth'(1);
            end
          end
          RD_POST: begin
            dqs_oe_q <= 1'b0;
            state    <= IDLE;
          end
        endcase
      end
    end
  end

  assign rpc.db_o     = db_q;
  assign rpc.db_oe_o  = db_oe_q;
  assign rpc.dqs_o    = dqs_q;
  assign rpc.dqs_n_o  = ~dqs_q;
  assign rpc.dqs_oe_o = dqs_oe_q;
  assign err_cnt_o    = err_cnt;
  assign busy_o       = (state != IDLE);

endmodule

// File: tb/tb_rpc_dram_responder.sv
// tb/tb_rpc_dram_responder.sv - directed self-checking bench for rpc_dram_responder
module tb_rpc_dram_responder;
  localparam int RL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  err_cnt;
  logic        busy;
  int          total = 0;
  int          bad = 0;
  int          shape_bad;
  logic [15:0] wr_words [0:15];
  logic [15:0] rd_words [0:15];

  rpc_dram_responder_if rpc();

  rpc_dram_responder dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .rpc       (rpc),
    .err_cnt_o (err_cnt),
    .busy_o    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got still running want finished");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    rpc.rpc_cs_ni = 1'b1;
    rpc.rpc_stb_i = 1'b0;
    rpc.db_i      = 16'h0;
    rpc.dqs_i     = 1'b0;
  endtask

  task automatic send_cmd(input logic [3:0] op, input logic [19:0] addr, input logic [5:0] len);
    rpc.rpc_cs_ni = 1'b0;
    rpc.rpc_stb_i = 1'b1;
    rpc.db_i      = {op, addr[11:0]};
    cyc();
    rpc.db_i      = {addr[19:12], len, 2'b00};
    cyc();
    rpc.rpc_stb_i = 1'b0;
    rpc.db_i      = 16'h0;
  endtask

  task automatic write_burst(input logic [19:0] addr, input logic [5:0] len);
    send_cmd(4'h1, addr, len);
    for (int i = 0; i <= int'(len); i++) begin
      rpc.dqs_i = 1'b1;
      rpc.db_i  = wr_words[i];
      cyc();
    end
    idle_bus();
  endtask

  // Collects the returned words and tallies any deviation in preamble/data/postamble shape.
  task automatic read_burst(input logic [19:0] addr, input logic [5:0] len);
    shape_bad = 0;
    send_cmd(4'h2, addr, len);
    for (int i = 1; i < RL; i++) begin
      if (rpc.dqs_oe_o !== 1'b0 || rpc.db_oe_o !== 1'b0 || busy !== 1'b1) shape_bad++;
      cyc();
    end
    if (rpc.dqs_oe_o !== 1'b1 || rpc.dqs_o !== 1'b0 || rpc.dqs_n_o !== 1'b1 || rpc.db_oe_o !== 1'b0) shape_bad++;
    cyc();
    for (int i = 0; i <= int'(len); i++) begin
      if (rpc.db_oe_o !== 1'b1 || rpc.dqs_o !== 1'b1 || rpc.dqs_n_o !== 1'b0 || rpc.dqs_oe_o !== 1'b1) shape_bad++;
      rd_words[i] = rpc.db_o;
      cyc();
    end
    if (rpc.dqs_oe_o !== 1'b1 || rpc.dqs_o !== 1'b0 || rpc.db_oe_o !== 1'b0) shape_bad++;
    cyc();
    if (rpc.dqs_oe_o !== 1'b0 || rpc.db_oe_o !== 1'b0 || busy !== 1'b0) shape_bad++;
    idle_bus();
  endtask

  task automatic test_reset();
    idle_bus();
    rst = 1'b1;
    cyc(); cyc(); cyc();
    total++;
    if ({rpc.db_o, rpc.db_oe_o, rpc.dqs_o, rpc.dqs_n_o, rpc.dqs_oe_o, err_cnt, busy} !== {16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0, 1'b0}) begin
      bad++;
      $display("FAIL reset_outputs: got db=%h oe=%b dqs=%b dqsn=%b dqsoe=%b err=%h busy=%b want 0000 0 0 1 0 00 0",
               rpc.db_o, rpc.db_oe_o, rpc.dqs_o, rpc.dqs_n_o, rpc.dqs_oe_o, err_cnt, busy);
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_write_read();
    for (int i = 0; i < 4; i++) wr_words[i] = 16'hA000 + 16'(i);
    write_burst(20'h00010, 6'd3);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL wr_done_busy: got %b want 0", busy); end
    read_burst(20'h00010, 6'd3);
    total++;
    if (shape_bad !== 0) begin bad++; $display("FAIL rd_shape: got %0d deviations want 0", shape_bad); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rd_words[i] !== 16'hA000 + 16'(i)) begin
        bad++; $display("FAIL rd_word%0d: got %h want %h", i, rd_words[i], 16'hA000 + 16'(i));
      end
    end
    total++;
    if (err_cnt !== 8'd0) begin bad++; $display("FAIL wr_rd_err: got %0d want 0", err_cnt); end
  endtask

  task automatic test_wrap();
    wr_words[0] = 16'h1111; wr_words[1] = 16'h2222; wr_words[2] = 16'h3333; wr_words[3] = 16'h4444;
    write_burst(20'h003FE, 6'd3);
    read_burst(20'h00000, 6'd1);
    total++;
    if (rd_words[0] !== 16'h3333 || rd_words[1] !== 16'h4444 || shape_bad !== 0) begin
      bad++; $display("FAIL wrap_low: got %h %h shape=%0d want 3333 4444 shape=0", rd_words[0], rd_words[1], shape_bad);
    end
    read_burst(20'h003FE, 6'd3);
    total++;
    if ({rd_words[0], rd_words[1], rd_words[2], rd_words[3]} !== 64'h1111_2222_3333_4444) begin
      bad++; $display("FAIL wrap_read: got %h %h %h %h want 1111 2222 3333 4444", rd_words[0], rd_words[1], rd_words[2], rd_words[3]);
    end
  endtask

  task automatic test_illegal_op();
    send_cmd(4'h7, 20'h00010, 6'd0);
    total++;
    if (busy !== 1'b0 || rpc.db_oe_o !== 1'b0 || rpc.dqs_oe_o !== 1'b0) begin
      bad++; $display("FAIL illegal_idle: got busy=%b oe=%b dqsoe=%b want 0 0 0", busy, rpc.db_oe_o, rpc.dqs_oe_o);
    end
    total++;
    if (err_cnt !== 8'd1) begin bad++; $display("FAIL illegal_err: got %0d want 1", err_cnt); end
    idle_bus();
    cyc();
    read_burst(20'h00010, 6'd3);
    total++;
    if (shape_bad !== 0 || rd_words[0] !== 16'hA000 || rd_words[3] !== 16'hA003) begin
      bad++; $display("FAIL illegal_then_read: got %h..%h shape=%0d want a000..a003 shape=0", rd_words[0], rd_words[3], shape_bad);
    end
  endtask

  task automatic test_write_timeout();
    wr_words[0] = 16'h5A5A;
    write_burst(20'h00020, 6'd0);
    send_cmd(4'h1, 20'h00020, 6'd0);
    rpc.db_i = 16'hDEAD;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL to_wait1: got busy=%b want 1", busy); end
    cyc();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL to_wait2: got busy=%b want 1", busy); end
    cyc();
    total++;
    if (busy !== 1'b0 || err_cnt !== 8'd2) begin
      bad++; $display("FAIL to_expire: got busy=%b err=%0d want 0 2", busy, err_cnt);
    end
    cyc();
    idle_bus();
    read_burst(20'h00020, 6'd0);
    total++;
    if (rd_words[0] !== 16'h5A5A) begin bad++; $display("FAIL to_mem_kept: got %h want 5a5a", rd_words[0]); end
    send_cmd(4'h1, 20'h00021, 6'd0);
    cyc();
    rpc.dqs_i = 1'b1;
    rpc.db_i  = 16'h7777;
    cyc();
    idle_bus();
    total++;
    if (busy !== 1'b0 || err_cnt !== 8'd2) begin
      bad++; $display("FAIL late_beat: got busy=%b err=%0d want 0 2", busy, err_cnt);
    end
    read_burst(20'h00021, 6'd0);
    total++;
    if (rd_words[0] !== 16'h7777) begin bad++; $display("FAIL late_beat_data: got %h want 7777", rd_words[0]); end
  endtask

  task automatic test_abort();
    send_cmd(4'h2, 20'h00010, 6'd7);
    cyc(); cyc(); cyc();
    cyc();
    total++;
    if (rpc.db_o !== 16'hA000 || rpc.db_oe_o !== 1'b1) begin
      bad++; $display("FAIL abort_beat0: got %h oe=%b want a000 1", rpc.db_o, rpc.db_oe_o);
    end
    cyc();
    total++;
    if (rpc.db_o !== 16'hA001) begin bad++; $display("FAIL abort_beat1: got %h want a001", rpc.db_o); end
    rpc.rpc_cs_ni = 1'b1;
    cyc();
    total++;
    if (rpc.db_oe_o !== 1'b0 || rpc.dqs_oe_o !== 1'b0 || busy !== 1'b0 || err_cnt !== 8'd2) begin
      bad++; $display("FAIL abort_release: got oe=%b dqsoe=%b busy=%b err=%0d want 0 0 0 2",
                      rpc.db_oe_o, rpc.dqs_oe_o, busy, err_cnt);
    end
    idle_bus();
    cyc();
  endtask

  task automatic test_saturate_and_reset();
    for (int i = 0; i < 253; i++) send_cmd(4'h0, 20'h0, 6'd0);
    total++;
    if (err_cnt !== 8'hFF) begin bad++; $display("FAIL sat_reach: got %h want ff", err_cnt); end
    for (int i = 0; i < 47; i++) send_cmd(4'h0, 20'h0, 6'd0);
    total++;
    if (err_cnt !== 8'hFF) begin bad++; $display("FAIL sat_hold: got %h want ff", err_cnt); end
    idle_bus();
    cyc();
    send_cmd(4'h2, 20'h00010, 6'd3);
    cyc(); cyc(); cyc(); cyc(); cyc();
    total++;
    if (rpc.db_oe_o !== 1'b1) begin bad++; $display("FAIL rst_pre_read: got oe=%b want 1", rpc.db_oe_o); end
    rst = 1'b1;
    cyc();
    total++;
    if ({rpc.db_o, rpc.db_oe_o, rpc.dqs_o, rpc.dqs_n_o, rpc.dqs_oe_o, err_cnt, busy} !== {16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0, 1'b0}) begin
      bad++; $display("FAIL rst_mid_read: got db=%h oe=%b dqs=%b dqsn=%b dqsoe=%b err=%h busy=%b want 0000 0 0 1 0 00 0",
                      rpc.db_o, rpc.db_oe_o, rpc.dqs_o, rpc.dqs_n_o, rpc.dqs_oe_o, err_cnt, busy);
    end
    rst = 1'b0;
    idle_bus();
    cyc();
  endtask

  initial begin
    rst = 1'b1;
    idle_bus();
    test_reset();
    test_write_read();
    test_wrap();
    test_illegal_op();
    test_write_timeout();
    test_abort();
    test_saturate_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rpc_dram_responder.md
Name: rpc_dram_responder

Overview:
- Device-side endpoint of the RPC DRAM link, the peer of the controller PHY pins (clk, cs_n, stb, dqs pair, 16-bit db).
- Decodes command frames, absorbs write bursts into a small internal word memory and returns read bursts with programmable latency.
- Serves as the synthesizable DRAM stand-in for FPGA loopback and as the protocol responder in controller verification.
- Operates SDR, one 16-bit word per clk_i; DDR serialization sits in the pad/IO layer outside this block.

Parameters:
- MemDepth, 1024, number of 16-bit words stored; power of two; index = addr[log2(MemDepth)-1:0].
- RdLatency, 4, cycles from the last command word to the read preamble; range 1..15.
- WrLatency, 2, maximum cycles from the last command word to the first write beat before timeout; range 1..15.
- AddrWidth, 20, command word address width.
- LenWidth, 6, burst length field; beats = len+1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- rpc_cs_ni  in  1  chip select, active low
- rpc_stb_i  in  1  command strobe, high marks a command word on db
- db_i  in  16  data/command bus from controller
- dqs_i  in  1  write data strobe from controller, high marks a valid beat
- db_o  out  16  read data to controller
- db_oe_o  out  1  db output enable
- dqs_o  out  1  read strobe
- dqs_n_o  out  1  complement of dqs_o while driven
- dqs_oe_o  out  1  dqs pair output enable
- err_cnt_o  out  8  saturating count of protocol errors
- busy_o  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst_i sampled high): state IDLE; db_o=0, db_oe_o=0, dqs_o=0, dqs_n_o=1, dqs_oe_o=0, err_cnt_o=0, busy_o=0. Memory contents are not reset.
- Command frame: two consecutive cycles with cs_n=0 and stb=1.
  - word0 = {op[3:0], addr[11:0]}
  - word1 = {addr[19:12], len[5:0], 2'b00}
  - op 4'h1 = WRITE, op 4'h2 = READ, any other op counts as an error and the FSM returns to IDLE.
- States:
  - IDLE: cs_n=0 and stb=1 -> CMD1 (latch word0).
  - CMD1: stb=1 -> latch word1 and decode. Result is WR_WAIT or RD_WAIT, or IDLE for an illegal op. If stb=0, count an error and go to IDLE.
  - WR_WAIT: dqs_i=1 -> store the beat and go to WR_DATA. If no beat arrives within WrLatency cycles, count an error and go to IDLE.
  - WR_DATA: on each cycle with dqs_i=1, mem[ptr] <= db_i and ptr increments. After len+1 stored beats -> IDLE. Cycles with dqs_i=0 are gaps and are legal.
  - RD_WAIT: count RdLatency-1 cycles, then -> RD_PRE.
  - RD_PRE: one cycle with dqs_oe_o=1, dqs_o=0, db_oe_o=0 -> RD_DATA.
  - RD_DATA: db_oe_o=1, db_o=mem[ptr], dqs_o=1 for every beat, ptr increments; lasts len+1 cycles -> RD_POST.
  - RD_POST: one cycle with dqs_oe_o=1, dqs_o=0, db_oe_o=0 -> IDLE.
- Read timing: the first read word appears exactly RdLatency+1 cycles after the word1 cycle. The memory is read with registered output, so ptr is prefetched one cycle ahead.
- Addressing: ptr starts at the frame address, increments by 1 per beat, and wraps modulo MemDepth. A burst crossing the top wraps to index 0.
- Abort: cs_n=1 in any state other than IDLE returns the FSM to IDLE next cycle and deasserts all oe outputs. Beats already written are kept. A WR_DATA abort counts an error; aborts in other states do not.
- stb=1 during WR_WAIT, WR_DATA, RD_WAIT, RD_PRE, RD_DATA or RD_POST: counts an error and is otherwise ignored. No command pipelining.
- err_cnt_o saturates at 8'hFF and holds. When two error sources occur in one cycle, the count increments by 1 only.
- dqs_n_o = ~dqs_o at all times.
- Reset mid-burst takes priority over every other event.

Test Plan:
1. Write then read back: WRITE addr 0x00010, len 3, beats 0xA000..0xA003, then READ of the same address and length. Expected: db_o=0xA000..0xA003 starting RdLatency+1=5 cycles after word1, preamble and postamble one cycle each, err_cnt_o=0.
2. Wrap-around: WRITE addr 0x003FE, len 3, data 0x1111..0x4444, then READ addr 0x00000, len 1. Expected: the read returns 0x3333, 0x4444.
3. Illegal op: word0 op=4'h7. Expected: FSM back to IDLE, no oe asserted, err_cnt_o=1; a following legal READ completes normally.
4. Write timeout: WRITE with dqs_i held low for WrLatency+1 cycles. Expected: err_cnt_o increments, busy_o falls, memory unchanged.
5. Abort: cs_n driven high during the second read beat of a len 7 read. Expected: db_oe_o and dqs_oe_o fall on the next cycle, FSM IDLE, err_cnt_o unchanged.
6. Reset and saturation: issue 300 illegal frames. Expected: err_cnt_o=0xFF. Then assert rst_i mid-read. Expected: all outputs take their reset values on the next cycle.
